// File: rtl/twire_pkg.sv
// twire_pkg: shared types and constants for the two-wire serial slave.
package twire_pkg;
    localparam int TWIRE_BYTE_W = 8;
    localparam logic TWIRE_ACK  = 1'b0;
    localparam logic TWIRE_NACK = 1'b1;
    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } twire_slv_state_t;
endpackage

// File: rtl/twire_slv_sync.sv
// twire_slv_sync: SCL/SDA synchronizer, optional majority filter (TWIRE_SLV_GLITCH_FLT_EN), START/STOP detection.
// Bus vector layout: bit 0 = SCL, bit 1 = SDA.
module twire_slv_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       async_rst,
    input  logic [1:0] i_bus,
    output logic       o_sda,
    output logic       o_scl_rise,
    output logic       o_scl_fall,
    output logic       o_start,
    output logic       o_stop
);
    logic [STAGES-1:0][1:0] r_sync;
    logic [1:0]             r_prev;
    logic [1:0]             w_clean;

    // Flops reset to the idle-bus level so release never fakes an edge.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) r_sync <= '1;
        else            r_sync <= {r_sync[STAGES-2:0], i_bus};
    end

`ifdef TWIRE_SLV_GLITCH_FLT_EN
    logic [2:0][1:0] r_hist;
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) r_hist <= '1;
        else            r_hist <= {r_hist[1:0], r_sync[STAGES-1]};
    end
    assign w_clean = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
    assign w_clean = r_sync[STAGES-1];
`endif

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) r_prev <= '1;
        else            r_prev <= w_clean;
    end

    assign o_sda      = w_clean[1];
    assign o_scl_rise = w_clean[0] & ~r_prev[0];
    assign o_scl_fall = ~w_clean[0] & r_prev[0];
    assign o_start    = w_clean[0] & r_prev[0] & r_prev[1] & ~w_clean[1];
    assign o_stop     = w_clean[0] & r_prev[0] & ~r_prev[1] & w_clean[1];
endmodule

// File: rtl/twire_slave.sv
// twire_slave: two-wire bus slave with register-pointer auto-increment and byte-wide register port.
// Optional input glitch filter enabled by defining TWIRE_SLV_GLITCH_FLT_EN.
module twire_slave
    import twire_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    async_rst,
    input  logic                    SCL,
    input  logic                    SDA_I,
    output logic                    SDA_O,
    output logic                    SDA_T,
    output logic [TWIRE_BYTE_W-1:0] reg_addr,
    output logic [TWIRE_BYTE_W-1:0] reg_wdata,
    output logic                    reg_wr,
    output logic                    reg_rd,
    input  logic [TWIRE_BYTE_W-1:0] reg_rdata,
    output logic                    busy
);
    twire_slv_state_t        r_state;
    logic [3:0]              r_cnt;
    logic [TWIRE_BYTE_W-1:0] r_sh, r_addr, r_wdata;
    logic                    r_rw, r_ack, r_fetch, r_sda_t, r_wr, r_rd, r_busy;
    logic                    w_sda, w_rise, w_fall, w_start, w_stop;
    logic [TWIRE_BYTE_W-1:0] w_byte;

    twire_slv_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .async_rst  (async_rst),
        .i_bus      ({SDA_I, SCL}),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_sh[TWIRE_BYTE_W-2:0], w_sda};

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rw    <= 1'b0;
            r_ack   <= 1'b0;
            r_fetch <= 1'b0;
            r_sda_t <= 1'b1;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_fetch <= r_rd;
            if (w_stop) begin
                r_state <= ST_IDLE;
                r_sda_t <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_start) begin
                r_state <= ST_DEV_ADDR;
                r_cnt   <= '0;
                r_sda_t <= 1'b1;
            end else begin
                // Read data arrives one clk after the fetch strobe.
                if (r_fetch) r_sh <= reg_rdata;
                case (r_state)
                    ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: if (w_rise) begin
                        r_sh  <= w_byte;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_ack <= 1'b0;
                            if (r_state == ST_DEV_ADDR) begin
                                r_state <= (w_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                                r_busy  <= r_busy | (w_byte[7:1] == DEV_ADDR);
                                r_rw    <= w_byte[0];
                            end else if (r_state == ST_REG_ADDR) begin
                                r_state <= ST_REG_ACK;
                                r_addr  <= w_byte;
                            end else begin
                                r_state <= ST_WR_ACK;
                                r_wdata <= w_byte;
                                r_wr    <= 1'b1;
                            end
                        end
                    end
                    ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: if (w_fall) begin
                        if (!r_ack) begin
                            r_ack   <= 1'b1;
                            r_sda_t <= TWIRE_ACK;
                            r_rd    <= (r_state == ST_DEV_ACK) & r_rw;
                            if (r_state == ST_WR_ACK) r_addr <= r_addr + 8'd1;
                        end else if (r_state == ST_DEV_ACK && r_rw) begin
                            r_state <= ST_RD_DATA;
                            r_sda_t <= r_sh[7];
                            r_sh    <= {r_sh[6:0], 1'b0};
                            r_cnt   <= 4'd1;
                        end else begin
                            r_state <= (r_state == ST_DEV_ACK) ? ST_REG_ADDR : ST_WR_DATA;
                            r_sda_t <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    ST_RD_DATA: if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            r_state <= ST_RD_ACK;
                            r_sda_t <= 1'b1;
                            r_ack   <= 1'b0;
                        end else begin
                            r_sda_t <= r_sh[7];
                            r_sh    <= {r_sh[6:0], 1'b0};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    ST_RD_ACK: if (w_rise && !r_ack) begin
                        if (w_sda == TWIRE_ACK) begin
                            r_ack  <= 1'b1;
                            r_addr <= r_addr + 8'd1;
                            r_rd   <= 1'b1;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end else if (w_fall && r_ack) begin
                        r_state <= ST_RD_DATA;
                        r_sda_t <= r_sh[7];
                        r_sh    <= {r_sh[6:0], 1'b0};
                        r_cnt   <= 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA_O     = 1'b0;
    assign SDA_T     = r_sda_t;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign reg_rd    = r_rd;
    assign busy      = r_busy;
endmodule

// File: doc/twire_slave.md
Name: twire_slave

Overview:
- Two-wire serial responder (slave), the other end of the TWireSerIntrfc master.
- Recognises START, STOP and repeated START, and matches a 7-bit device address.
- Accepts a register-address byte, then auto-increments through a byte-wide external register interface for writes and reads.
- Used as the bus-side model/target in loopback benches against the master, and as synthesizable peripheral logic.

Parameters:
DEV_ADDR, 7'h50, 7-bit device address this block responds to
SYNC_STAGES, 2, synchronizer depth on SCL and SDA_I (minimum 2)

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency
async_rst  in  1  asynchronous, active-low reset
SCL  in  1  bus clock from the master
SDA_I  in  1  bus data input
SDA_O  out  1  bus data output value; always 0 when driving
SDA_T  out  1  tristate enable; 1 = released (high-Z), 0 = drive SDA_O
reg_addr  out  8  current register pointer
reg_wdata  out  8  write data, valid with reg_wr
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read-fetch strobe at reg_addr
reg_rdata  in  8  read data, sampled exactly one clk after reg_rd
busy  out  1  high from an address-matched START until STOP

Behaviour:
- Reset (async_rst=0), effective immediately, regardless of state:
  - SDA_T=1, SDA_O=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, state IDLE.
- Input conditioning:
  - SCL and SDA_I pass through SYNC_STAGES flops, then one edge-detect register.
  - All decisions use the synchronized values.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- Bit timing:
  - Receive bits are sampled on the synchronized SCL rise, MSB first.
  - Drive changes (ACK, read bits) are applied on the synchronized SCL fall.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Global transitions:
  - START in any state -> DEV_ADDR, bit counter cleared, SDA_T=1. This covers repeated START.
  - STOP in any state -> IDLE, SDA_T=1, busy=0.
- DEV_ADDR: shift 8 bits.
  - Upper 7 bits == DEV_ADDR -> DEV_ACK, busy=1.
  - Mismatch -> IGNORE; SDA_T stays 1 until STOP/START.
- DEV_ACK: SDA_T=0 from the SCL fall after bit 8 to the SCL fall after bit 9.
  - R/W=0 -> REG_ADDR.
  - R/W=1 -> issue reg_rd at ACK start, capture reg_rdata into the shift register, then RD_DATA.
- REG_ADDR: shift 8 bits -> load reg_addr, then REG_ACK (ACK as above), then WR_DATA.
- WR_DATA: shift 8 bits -> WR_ACK.
  - reg_wdata loaded and reg_wr pulsed one clk after the 8th SCL rise.
  - ACK driven; reg_addr increments by 1 at the ACK SCL fall.
  - Then back to WR_DATA.
- RD_DATA: drive the shift-register MSB on each SCL fall (SDA_T=0 when bit=0, released when bit=1). After 8 bits, release SDA -> RD_ACK.
- RD_ACK: sample the master's bit on SCL rise.
  - ACK (0): reg_addr+1, reg_rd pulse, capture next byte -> RD_DATA.
  - NACK (1) -> IGNORE.
- reg_addr wraps 8'hFF -> 8'h00 on increment, for both write and read.
- STOP arriving mid-byte: partial byte discarded, no reg_wr.
- reg_addr is retained across transactions; only REG_ADDR or reset changes it, apart from the increments above.

Optional Feature:
- Macro: TWIRE_SLV_GLITCH_FLT_EN.
- Defined:
  - A 3-sample majority filter follows the synchronizers on both SCL and SDA.
  - Single-clk pulses are suppressed.
  - Adds 2 clk of input latency; the 8x clock-ratio requirement still holds.
- Undefined: no filter; synchronizer output feeds edge detection directly.

Decomposition:
- twire_pkg gains:
  - twire_slv_state_t enum (the states above).
  - TWIRE_BYTE_W=8.
  - TWIRE_ACK=1'b0 and TWIRE_NACK=1'b1.
- One sub-module, twire_slv_sync: synchronizer + optional majority filter + edge/START/STOP detect. Instantiated once, with SCL and SDA as a 2-bit vector.

Test Plan:
- Single write:
  - Stimulus: master writes dev 0x50/W, reg 0x10, data 0xA0, STOP.
  - Response: three ACKs (SDA_T=0 during each 9th bit); one reg_wr with reg_addr=0x10, reg_wdata=0xA0; busy falls after STOP.
- Burst write with wrap:
  - Stimulus: reg 0xFE, data 0x11, 0x22, 0x33.
  - Response: reg_wr at addresses 0xFE, 0xFF, 0x00 with the matching data; final reg_addr=0x01.
- Read with repeated START:
  - Stimulus: W reg 0x20, Sr, dev 0x50/R, read 2 bytes with ACK then NACK, STOP. Bench memory returns 0x5A@0x20 and 0xC3@0x21.
  - Response: SDA carries 0x5A then 0xC3, MSB first; reg_rd pulses for 0x20 and 0x21; no third reg_rd after the NACK.
- Address mismatch:
  - Stimulus: dev 0x51/W, reg 0x00, data 0xFF.
  - Response: SDA_T=1 throughout, no reg_wr, busy=0.
- Reset mid-transaction:
  - Stimulus: assert async_rst=0 during bit 4 of a data byte.
  - Response: same cycle, SDA_T=1, reg_wr=0, busy=0. After release, a fresh START + write to 0x10 succeeds.
- Loopback:
  - Stimulus: TWireSerIntrfc master connected through a pull-up model; writes 0x3C to 0x05, then reads 0x05.
  - Response: master valid_out with data_out=0x3C, error=0.
